// File: rtl/ddr_package.sv
// ---------------------------------------------------------------------------
// ddr_package
// Shared definitions for the DDR power-up / initialisation sequencer:
//   - ddr_state_e : sequencer state encoding
//   - clamp_min1  : raises a timing parameter to at least one cycle
//   - max_int     : larger of two integers (used to size the counters)
// ---------------------------------------------------------------------------
package ddr_package;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_CKE_WAIT = 3'd2,
    ST_CKE_RAMP = 3'd3,
    ST_XPR_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } ddr_state_e;

  // A phase must last at least one cycle, so smaller requests are raised to 1.
  function automatic int clamp_min1(input int value);
    if (value < 32'sd1) begin
      return 32'sd1;
    end else begin
      return value;
    end
  endfunction

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ddr_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddr_init_sequencer_if
// Control/status bundle of the DDR init sequencer.
//   start      : single-cycle re-init request        (controller -> sequencer)
//   clk_stable : DRAM clock is stable                 (controller -> sequencer)
//   reset_n    : DRAM reset, active-low               (sequencer -> DRAM)
//   cke        : per-rank clock enable                (sequencer -> DRAM)
//   busy       : sequence in progress                 (sequencer -> controller)
//   init_done  : initialisation complete              (sequencer -> controller)
//   timeout    : sticky watchdog flag                 (sequencer -> controller)
// Modports: master = controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface ddr_init_sequencer_if #(
  parameter int NUM_RANKS = 2
);
  logic                 start;
  logic                 clk_stable;
  logic                 reset_n;
  logic [NUM_RANKS-1:0] cke;
  logic                 busy;
  logic                 init_done;
  logic                 timeout;

  modport master (
    output start, clk_stable,
    input  reset_n, cke, busy, init_done, timeout
  );

  modport slave (
    input  start, clk_stable,
    output reset_n, cke, busy, init_done, timeout
  );
endinterface

// File: rtl/ddr_init_timer.sv
// ---------------------------------------------------------------------------
// ddr_init_timer
// Loadable saturating down-counter.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : load load_value (has priority over enable)
//   load_value   : value loaded into the counter
//   enable       : decrement by one, stopping at zero
//   expired      : counter is zero
// Loading N-1 makes expired true in the N-th enabled cycle after the load.
// ---------------------------------------------------------------------------
module ddr_init_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Counter register: load, else saturating decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ddr_init_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_init_sequencer
// DRAM power-up sequencer: holds reset_n low, releases it, raises CKE rank by
// rank, waits tXPR and reports init_done. A watchdog aborts to IDLE with a
// sticky timeout flag if the sequence stalls.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : control/status bundle (slave side), see ddr_init_sequencer_if
// All outputs are registered and computed from the next state, so they
// change on the same edge as the state and clear asynchronously on reset.
// ---------------------------------------------------------------------------
module ddr_init_sequencer
  import ddr_package::*;
#(
  parameter int NUM_RANKS  = 2,
  parameter int T_RESET    = 20,
  parameter int T_CKE      = 50,
  parameter int T_STAGGER  = 0,
  parameter int T_XPR      = 30,
  parameter int TIMEOUT    = 1000,
  parameter int AUTO_START = 1
) (
  input logic                 clock,
  input logic                 reset,
  ddr_init_sequencer_if.slave bus
);

  localparam int TR   = clamp_min1(T_RESET);
  localparam int TC   = clamp_min1(T_CKE);
  localparam int TX   = clamp_min1(T_XPR);
  localparam int TO   = clamp_min1(TIMEOUT);
  localparam int SG   = (T_STAGGER < 32'sd0) ? 32'sd0 : T_STAGGER;
  localparam int MAXP = max_int(max_int(max_int(TR, TC), max_int(TX, TO)), SG);
  localparam int CW   = $clog2(MAXP) + 32'sd1;

  localparam logic [CW-1:0] RST_LOAD  = CW'(TR - 32'sd1);
  localparam logic [CW-1:0] CKE_LOAD  = CW'(TC - 32'sd1);
  localparam logic [CW-1:0] STAG_LOAD = CW'(clamp_min1(SG) - 32'sd1);
  // tXPR is measured from the last CKE rise; the ramp's final cycle is its
  // first cycle, so XPR_WAIT itself lasts TX-1 cycles (skipped when TX=1).
  localparam logic [CW-1:0] XPR_LOAD  = CW'((TX >= 32'sd2) ? (TX - 32'sd2) : 32'sd0);
  localparam logic [CW-1:0] WD_LOAD   = CW'(TO - 32'sd1);
  localparam logic [NUM_RANKS-1:0] CKE_FIRST =
    (SG == 32'sd0) ? {NUM_RANKS{1'b1}} : NUM_RANKS'(1'b1);

  ddr_state_e           state_r, state_s;
  logic [NUM_RANKS-1:0] cke_r, cke_s;
  logic                 timeout_r, timeout_s;
  logic                 reset_n_r, busy_r, init_done_r, first_r;
  logic                 phase_load_s, phase_en_s, phase_expired_s;
  logic [CW-1:0]        phase_value_s;
  logic                 wd_load_s, wd_en_s, wd_expired_s;

  ddr_init_timer #(.WIDTH(CW)) phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (phase_load_s),
    .load_value (phase_value_s),
    .enable     (phase_en_s),
    .expired    (phase_expired_s)
  );

  ddr_init_timer #(.WIDTH(CW)) watchdog_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (wd_load_s),
    .load_value (WD_LOAD),
    .enable     (wd_en_s),
    .expired    (wd_expired_s)
  );

  // Next-state, timer control and next output values.
  always_comb begin
    state_s       = state_r;
    cke_s         = cke_r;
    timeout_s     = timeout_r;
    phase_load_s  = 1'b0;
    phase_value_s = {CW{1'b0}};
    phase_en_s    = 1'b0;
    wd_load_s     = 1'b0;
    wd_en_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // Auto-start fires only on the first cycle after reset release.
        if (bus.start || ((state_r == ST_IDLE) && first_r && (AUTO_START != 32'sd0))) begin
          state_s       = ST_RST_LOW;
          cke_s         = {NUM_RANKS{1'b0}};
          timeout_s     = 1'b0;
          phase_load_s  = 1'b1;
          phase_value_s = RST_LOAD;
          wd_load_s     = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_RST_LOW, ST_CKE_WAIT, ST_CKE_RAMP, ST_XPR_WAIT: begin
        wd_en_s = 1'b1;
        if (wd_expired_s) begin
          state_s   = ST_IDLE;
          cke_s     = {NUM_RANKS{1'b0}};
          timeout_s = 1'b1;
        end else if (state_r == ST_RST_LOW) begin
          // Reset time only accrues while the DRAM clock is stable.
          cke_s      = {NUM_RANKS{1'b0}};
          phase_en_s = bus.clk_stable;
          if (bus.clk_stable && phase_expired_s) begin
            state_s       = ST_CKE_WAIT;
            phase_load_s  = 1'b1;
            phase_value_s = CKE_LOAD;
          end else begin
            state_s = ST_RST_LOW;
          end
        end else if (!bus.clk_stable) begin
          // Losing the clock after reset release restarts the reset phase.
          state_s       = ST_RST_LOW;
          cke_s         = {NUM_RANKS{1'b0}};
          phase_load_s  = 1'b1;
          phase_value_s = RST_LOAD;
        end else begin
          phase_en_s = 1'b1;
          case (state_r)
            ST_CKE_WAIT: begin
              if (phase_expired_s) begin
                state_s       = ST_CKE_RAMP;
                cke_s         = CKE_FIRST;
                phase_load_s  = 1'b1;
                phase_value_s = STAG_LOAD;
              end else begin
                state_s = ST_CKE_WAIT;
              end
            end
            ST_CKE_RAMP: begin
              if (&cke_r) begin
                state_s       = (TX == 32'sd1) ? ST_DONE : ST_XPR_WAIT;
                phase_load_s  = 1'b1;
                phase_value_s = XPR_LOAD;
              end else if (phase_expired_s) begin
                // Next rank rises; earlier ranks stay set.
                cke_s         = cke_r | (cke_r << 1'b1);
                phase_load_s  = 1'b1;
                phase_value_s = STAG_LOAD;
              end else begin
                state_s = ST_CKE_RAMP;
              end
            end
            ST_XPR_WAIT: begin
              if (phase_expired_s) begin
                state_s = ST_DONE;
              end else begin
                state_s = ST_XPR_WAIT;
              end
            end
            default: begin
              state_s = ST_IDLE;
              cke_s   = {NUM_RANKS{1'b0}};
            end
          endcase
        end
      end
      default: begin
        state_s = ST_IDLE;
        cke_s   = {NUM_RANKS{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cke_r       <= {NUM_RANKS{1'b0}};
      timeout_r   <= 1'b0;
      reset_n_r   <= 1'b0;
      busy_r      <= 1'b0;
      init_done_r <= 1'b0;
      first_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      cke_r       <= cke_s;
      timeout_r   <= timeout_s;
      reset_n_r   <= (state_s == ST_CKE_WAIT) || (state_s == ST_CKE_RAMP) ||
                     (state_s == ST_XPR_WAIT) || (state_s == ST_DONE);
      busy_r      <= (state_s == ST_RST_LOW) || (state_s == ST_CKE_WAIT) ||
                     (state_s == ST_CKE_RAMP) || (state_s == ST_XPR_WAIT);
      init_done_r <= (state_s == ST_DONE);
      first_r     <= 1'b0;
    end
  end

  assign bus.reset_n   = reset_n_r;
  assign bus.cke       = cke_r;
  assign bus.busy      = busy_r;
  assign bus.init_done = init_done_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: doc/ddr_init_sequencer.md
DDR_INIT_SEQUENCER -- requirements
Module: ddr_init_sequencer

Interface
REQ-001 Parameter NUM_RANKS, default 2, number of CKE outputs (1..8).
REQ-002 Parameter T_RESET, default 20, cycles reset_n held low; values below 1 SHALL be treated as 1.
REQ-003 Parameter T_CKE, default 50, cycles from reset_n rise to first CKE rise; values below 1 SHALL be treated as 1.
REQ-004 Parameter T_STAGGER, default 0, cycles between successive rank CKE rises; 0 means all ranks rise together.
REQ-005 Parameter T_XPR, default 30, cycles from last CKE rise to init_done; values below 1 SHALL be treated as 1.
REQ-006 Parameter TIMEOUT, default 1000, watchdog limit in cycles from leaving IDLE.
REQ-007 Parameter AUTO_START, default 1; 1 means the sequence starts automatically after reset.
REQ-008 clock  input  1  single clock; all logic on rising edge.
REQ-009 reset  input  1  asynchronous, active-high.
REQ-010 start  input  1  single-cycle re-init request.
REQ-011 clk_stable  input  1  high when the DRAM clock is stable; gates the T_RESET count.
REQ-012 reset_n  output  1  DRAM reset, active-low.
REQ-013 cke  output  NUM_RANKS  per-rank clock enable.
REQ-014 busy  output  1  high in every state except IDLE and DONE.
REQ-015 init_done  output  1  high only in DONE.
REQ-016 timeout  output  1  sticky watchdog flag.

Function
REQ-017 States SHALL be IDLE, RST_LOW, CKE_WAIT, CKE_RAMP, XPR_WAIT, DONE.
REQ-018 IDLE -> RST_LOW on start, or on the first cycle after reset release when AUTO_START=1.
REQ-019 In RST_LOW, reset_n=0 and cke=0; the counter increments only in cycles with clk_stable=1; exit to CKE_WAIT after T_RESET counted cycles.
REQ-020 CKE_WAIT: reset_n=1, cke=0; exit to CKE_RAMP after T_CKE cycles.
REQ-021 CKE_RAMP: rank 0 rises on entry, rank i rises i*T_STAGGER cycles later; cke bits, once set, stay set; exit to XPR_WAIT on the cycle after the last rank rises.
REQ-022 XPR_WAIT: exit to DONE after T_XPR cycles; init_done rises on DONE entry.
REQ-023 DONE: hold outputs; start returns the block to RST_LOW, and cke and init_done clear in the same cycle.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 The watchdog counts every cycle while busy; when it reaches TIMEOUT, set timeout, go to IDLE, and drive reset_n=0, cke=0.
REQ-026 timeout SHALL clear only on reset or on an accepted start.
REQ-027 If clk_stable falls during CKE_WAIT, CKE_RAMP or XPR_WAIT, the block SHALL return to RST_LOW with the count cleared.
REQ-028 Counter width SHALL be $clog2 of the largest timing parameter plus 1; counters SHALL saturate and never wrap.

Reset
REQ-029 On reset: state=IDLE, reset_n=0, cke=0, busy=0, init_done=0, timeout=0, all counters 0.
REQ-030 Reset asserted mid-sequence SHALL force the reset values immediately, without waiting for a clock edge.

Structure
REQ-031 The state enum and the minimum-clamp function SHALL live in ddr_package.
REQ-032 One sub-module, ddr_init_timer, a loadable saturating down-counter with enable and an expiry flag, SHALL be instantiated for phase timing and again for the watchdog.

Verification
REQ-033 Default parameters, clk_stable=1 -> reset_n low for 20 cycles, cke rises 50 cycles later, init_done rises 30 cycles after that.
REQ-034 NUM_RANKS=4, T_STAGGER=3 -> cke goes 0001, 0011, 0111, 1111 at 3-cycle spacing.
REQ-035 clk_stable held 0 for 10 cycles in RST_LOW -> reset_n low for 30 cycles total.
REQ-036 TIMEOUT=40, clk_stable=0 -> timeout=1 at cycle 40 and state returns to IDLE; start then clears timeout.
REQ-037 start pulse in DONE -> init_done=0 and reset_n=0 on the next cycle; the full sequence repeats.
REQ-038 reset asserted in CKE_RAMP -> cke=0 and reset_n=0 without waiting for a clock edge.
